wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: CNT_W, default 32, width of the committed-writeback counter.
REQ-002 Port: clk_i  input  1  pipeline clock, all state updates on rising edge.
REQ-003 Port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 Port: RegWrite_i  input  1  writeback enable from MEM/WB stage.
REQ-005 Port: MemToReg_i  input  1  writeback source select: 1 = memory data, 0 = ALU result.
REQ-006 Port: ReadData_i  input  32  load data from MEM/WB.
REQ-007 Port: ALUResult_i  input  32  ALU result from MEM/WB.
REQ-008 Port: RDaddr_i  input  5  destination register index from MEM/WB.
REQ-009 Port: RSaddr_i  input  5  read port A index, from ID stage.
REQ-010 Port: RTaddr_i  input  5  read port B index, from ID stage.
REQ-011 Port: RSdata_o  output  32  read port A data.
REQ-012 Port: RTdata_o  output  32  read port B data.
REQ-013 Port: WBdata_o  output  32  selected writeback value, for forwarding into EX.
REQ-014 Port: WBcount_o  output  CNT_W  count of committed register writes.

Function
REQ-015 WBdata_o SHALL be combinational: ReadData_i when MemToReg_i=1, else ALUResult_i; it is valid regardless of RegWrite_i.
REQ-016 Storage SHALL be 31 x 32-bit registers, indices 1..31; index 0 has no storage.
REQ-017 On a rising edge with RegWrite_i=1 and RDaddr_i!=0, register[RDaddr_i] SHALL take WBdata_o.
REQ-018 RegWrite_i=1 with RDaddr_i=0 SHALL change no register and SHALL NOT increment WBcount_o.
REQ-019 RegWrite_i=0 (bubble) SHALL change no state; MemToReg_i, ReadData_i, ALUResult_i and RDaddr_i are don't-care then.
REQ-020 Reads SHALL be combinational; index 0 SHALL always return 32'h0 on either port.
REQ-021 Both read ports SHALL be independent; RSaddr_i=RTaddr_i returns identical data on both.
REQ-022 WBcount_o SHALL increment by 1 on every edge on which REQ-017 writes; it SHALL wrap from 2^CNT_W-1 to 0 without flag or stall.
REQ-023 Same-cycle read of the register being written: behaviour is defined by REQ-029/REQ-030.
REQ-024 Back-to-back writes to the same index on consecutive edges SHALL each take effect; the last one wins.

Reset
REQ-025 rst_i=0 SHALL asynchronously clear registers 1..31 to 32'h0 and WBcount_o to 0, without waiting for clk_i.
REQ-026 While rst_i=0, writes SHALL be ignored and RSdata_o/RTdata_o SHALL read 32'h0; WBdata_o stays the combinational mux.
REQ-027 Reset asserted mid-operation SHALL discard all register contents; the first write after release occurs on the first rising edge with rst_i=1.

Configuration
REQ-028 Macro WB_BYPASS_EN SHALL select write-to-read bypass.
REQ-029 With WB_BYPASS_EN defined: when RegWrite_i=1, RDaddr_i!=0 and RSaddr_i (RTaddr_i) equals RDaddr_i, RSdata_o (RTdata_o) SHALL return WBdata_o in the same cycle, suppressed while rst_i=0.
REQ-030 Without WB_BYPASS_EN: read ports SHALL return stored contents only; the written value is visible from the cycle after the write edge.

Verification
REQ-031 Reset: drive rst_i=0 mid-run after writing r5=32'hDEADBEEF -> RSdata_o for RSaddr_i=5 reads 32'h0 immediately and WBcount_o=0.
REQ-032 ALU write: RegWrite_i=1, MemToReg_i=0, ALUResult_i=32'h0000_1234, RDaddr_i=8, one edge -> RSaddr_i=8 reads 32'h0000_1234, WBcount_o=1.
REQ-033 Load write: RegWrite_i=1, MemToReg_i=1, ReadData_i=32'hCAFE_F00D, ALUResult_i=32'h1, RDaddr_i=31 -> r31=32'hCAFE_F00D; bubble next cycle with RDaddr_i=31, ALUResult_i=32'h0 -> r31 unchanged, count unchanged.
REQ-034 r0: RegWrite_i=1, RDaddr_i=0, ALUResult_i=32'hFFFF_FFFF -> RSaddr_i=0 and RTaddr_i=0 read 32'h0, WBcount_o unchanged.
REQ-035 Bypass: RegWrite_i=1, RDaddr_i=3, ALUResult_i=32'h55, RSaddr_i=3, r3 previously 32'h11 -> before edge RSdata_o=32'h55 with WB_BYPASS_EN, 32'h11 without; both read 32'h55 after the edge.
REQ-036 Wrap: CNT_W=4, 16 valid writes from reset -> WBcount_o=0 after the 16th edge, 1 after the 17th.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile - MIPS-style writeback stage plus 31 x 32-bit register file.
//
// Writeback mux selects load data or the ALU result. That value is written to
// register RDaddr_i on a rising clk_i when RegWrite_i=1 and RDaddr_i!=0.
// Register 0 has no storage and always reads zero. The block also counts
// committed writes.
//
// Optional feature, selected by defining the macro WB_BYPASS_EN:
//   When defined, a read port whose index matches the register being written
//   in the same cycle returns the writeback value combinationally.
//   When undefined, read ports return stored contents only.
//
// Ports
//   clk_i        in   1      pipeline clock, rising edge
//   rst_i        in   1      asynchronous active-low reset
//   RegWrite_i   in   1      writeback enable
//   MemToReg_i   in   1      1 = ReadData_i, 0 = ALUResult_i
//   ReadData_i   in   32     load data
//   ALUResult_i  in   32     ALU result
//   RDaddr_i     in   5      destination register index
//   RSaddr_i     in   5      read port A index
//   RTaddr_i     in   5      read port B index
//   RSdata_o     out  32     read port A data
//   RTdata_o     out  32     read port B data
//   WBdata_o     out  32     selected writeback value (forwarding)
//   WBcount_o    out  CNT_W  committed-write counter, wraps silently
module wb_regfile #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic             MemToReg_i,
  input  logic [31:0]      ReadData_i,
  input  logic [31:0]      ALUResult_i,
  input  logic [4:0]       RDaddr_i,
  input  logic [4:0]       RSaddr_i,
  input  logic [4:0]       RTaddr_i,
  output logic [31:0]      RSdata_o,
  output logic [31:0]      RTdata_o,
  output logic [31:0]      WBdata_o,
  output logic [CNT_W-1:0] WBcount_o
);

  logic [31:0]      regs [1:31];
  logic [CNT_W-1:0] cnt;
  logic             wr_en;

  assign WBdata_o  = MemToReg_i ? ReadData_i : ALUResult_i;
  assign wr_en     = RegWrite_i && (RDaddr_i != 5'd0);
  assign WBcount_o = cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regs <= '{default: '0};
      cnt  <= '0;
    end else if (wr_en) begin
      regs[RDaddr_i] <= WBdata_o;
      cnt            <= cnt + CNT_W'(1);
    end
  end

  // Read port A. Output is forced to zero while reset is held, so the bypass
  // path cannot leak the writeback value during reset.
  always_comb begin
    RSdata_o = '0;
    if (rst_i && (RSaddr_i != 5'd0)) begin
`ifdef WB_BYPASS_EN
      if (wr_en && (RSaddr_i == RDaddr_i))
        RSdata_o = WBdata_o;
      else
        RSdata_o = regs[RSaddr_i];
`else
      RSdata_o = regs[RSaddr_i];
`endif
    end
  end

  // Read port B. Same behaviour as port A.
  always_comb begin
    RTdata_o = '0;
    if (rst_i && (RTaddr_i != 5'd0)) begin
`ifdef WB_BYPASS_EN
      if (wr_en && (RTaddr_i == RDaddr_i))
        RTdata_o = WBdata_o;
      else
        RTdata_o = regs[RTaddr_i];
`else
      RTdata_o = regs[RTaddr_i];
`endif
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile.
//
// Two instances share one set of inputs:
//   - the default 32-bit counter instance
//   - a CNT_W=4 instance, used to exercise counter wrap
//
// A behavioural model (array + integer count) predicts all outputs. The model
// is checked on every falling edge. Directed checks with literal values pin
// the model at key points.
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        RegWrite_i = 1'b0;
  logic        MemToReg_i = 1'b0;
  logic [31:0] ReadData_i = '0;
  logic [31:0] ALUResult_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic [4:0]  RSaddr_i = '0;
  logic [4:0]  RTaddr_i = '0;

  logic [31:0] rs_a, rt_a, wb_a;
  logic [31:0] cnt_a;
  logic [31:0] rs_b, rt_b, wb_b;
  logic [3:0]  cnt_b;

  wb_regfile dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .ReadData_i(ReadData_i), .ALUResult_i(ALUResult_i), .RDaddr_i(RDaddr_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(rs_a), .RTdata_o(rt_a),
    .WBdata_o(wb_a), .WBcount_o(cnt_a)
  );

  wb_regfile #(.CNT_W(4)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .ReadData_i(ReadData_i), .ALUResult_i(ALUResult_i), .RDaddr_i(RDaddr_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RSdata_o(rs_b), .RTdata_o(rt_b),
    .WBdata_o(wb_b), .WBcount_o(cnt_b)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain storage array and an unbounded write count.
  bit [31:0] mdl [32];
  bit [31:0] mcount;

  function automatic bit [31:0] m_wb();
    return MemToReg_i ? ReadData_i : ALUResult_i;
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] a);
    if (!rst_i || a == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (RegWrite_i && RDaddr_i != 0 && a == RDaddr_i) return m_wb();
`endif
    return mdl[a];
  endfunction

  always @(negedge rst_i) begin
    foreach (mdl[i]) mdl[i] = '0;
    mcount = 0;
  end

  always @(posedge clk_i) begin
    if (rst_i && RegWrite_i && RDaddr_i != 0) begin
      mdl[RDaddr_i] = m_wb();
      mcount++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    chk("rs_a",  rs_a,  m_read(RSaddr_i));
    chk("rt_a",  rt_a,  m_read(RTaddr_i));
    chk("rs_b",  rs_b,  m_read(RSaddr_i));
    chk("rt_b",  rt_b,  m_read(RTaddr_i));
    chk("wb_a",  wb_a,  m_wb());
    chk("wb_b",  wb_b,  m_wb());
    chk("cnt_a", cnt_a, mcount);
    chk("cnt_b", {28'h0, cnt_b}, {28'h0, mcount[3:0]});
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input bit [4:0] rd, input bit [31:0] v);
    RegWrite_i  = 1'b1;
    MemToReg_i  = 1'b0;
    ALUResult_i = v;
    RDaddr_i    = rd;
    cyc();
    RegWrite_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    cyc(); cyc();
    RSaddr_i = 5'd8; RTaddr_i = 5'd31; #1;
    chk("reset_rs", rs_a, 32'h0);
    chk("reset_cnt", cnt_a, 32'h0);
    rst_i = 1'b1;
    cyc();

    // ALU write to r8.
    RegWrite_i = 1'b1; MemToReg_i = 1'b0; ALUResult_i = 32'h0000_1234; RDaddr_i = 5'd8;
    RSaddr_i = 5'd8; RTaddr_i = 5'd0;
    cyc();
    RegWrite_i = 1'b0; #1;
    chk("alu_r8", rs_a, 32'h0000_1234);
    chk("alu_cnt", cnt_a, 32'd1);

    // Load write to r31, then bubble must not disturb it.
    RegWrite_i = 1'b1; MemToReg_i = 1'b1; ReadData_i = 32'hCAFE_F00D; ALUResult_i = 32'h1;
    RDaddr_i = 5'd31; RSaddr_i = 5'd31; #1;
    chk("load_wbdata", wb_a, 32'hCAFE_F00D);
    cyc();
    RegWrite_i = 1'b0; MemToReg_i = 1'b0; ALUResult_i = 32'h0;
    cyc();
    chk("bubble_r31", rs_a, 32'hCAFE_F00D);
    chk("bubble_cnt", cnt_a, 32'd2);

    // Writes to r0 are discarded and not counted.
    RegWrite_i = 1'b1; RDaddr_i = 5'd0; ALUResult_i = 32'hFFFF_FFFF;
    RSaddr_i = 5'd0; RTaddr_i = 5'd0;
    cyc();
    chk("r0_rs", rs_a, 32'h0);
    chk("r0_rt", rt_a, 32'h0);
    chk("r0_wbdata", wb_a, 32'hFFFF_FFFF);
    chk("r0_cnt", cnt_a, 32'd2);
    RegWrite_i = 1'b0;

    // Same-cycle read of register being written.
    wr(5'd3, 32'h11);
    RegWrite_i = 1'b1; MemToReg_i = 1'b0; ALUResult_i = 32'h55; RDaddr_i = 5'd3;
    RSaddr_i = 5'd3; RTaddr_i = 5'd3; #1;
`ifdef WB_BYPASS_EN
    chk("bypass_pre", rs_a, 32'h55);
`else
    chk("bypass_pre", rs_a, 32'h11);
`endif
    cyc();
    RegWrite_i = 1'b0; #1;
    chk("bypass_post_rs", rs_a, 32'h55);
    chk("bypass_post_rt", rt_a, 32'h55);
    chk("bypass_cnt", cnt_a, 32'd4);

    // Back-to-back writes to one index: the last one wins.
    RSaddr_i = 5'd10;
    RegWrite_i = 1'b1; RDaddr_i = 5'd10; ALUResult_i = 32'hA;
    cyc();
    ALUResult_i = 32'hB;
    cyc();
    RegWrite_i = 1'b0; #1;
    chk("b2b_r10", rs_a, 32'hB);

    // Fill r1..r31 with distinct values, then read back on both ports.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 + 32'(i) * 32'h0001_0203);
    for (int i = 1; i < 32; i++) begin
      RSaddr_i = 5'(i); RTaddr_i = 5'(32 - i);
      cyc();
    end
    RSaddr_i = 5'd1; RTaddr_i = 5'd31; #1;
    chk("fill_r1", rs_a, 32'h1001_0203);
    chk("fill_r31", rt_a, 32'h101F_3E5D);
    chk("fill_cnt", cnt_a, 32'd37);
    chk("fill_cnt4", {28'h0, cnt_b}, 32'd5);

    // Asynchronous reset mid-run discards contents immediately.
    wr(5'd5, 32'hDEAD_BEEF);
    RSaddr_i = 5'd5; #1;
    chk("pre_rst_r5", rs_a, 32'hDEAD_BEEF);
    #2 rst_i = 1'b0; #1;
    chk("async_rst_r5", rs_a, 32'h0);
    chk("async_rst_cnt", cnt_a, 32'h0);
    // Writes during reset are ignored.
    RegWrite_i = 1'b1; RDaddr_i = 5'd5; ALUResult_i = 32'h1234_5678;
    cyc();
    chk("rst_write_ignored", rs_a, 32'h0);
    chk("rst_wbdata", wb_a, 32'h1234_5678);
    // First edge after release commits.
    RDaddr_i = 5'd7; ALUResult_i = 32'h77; RSaddr_i = 5'd7;
    #2 rst_i = 1'b1;
    cyc();
    RegWrite_i = 1'b0; #1;
    chk("post_rst_r7", rs_a, 32'h77);
    chk("post_rst_cnt", cnt_a, 32'd1);

    // Counter wrap on the 4-bit instance: 16 writes from reset.
    #2 rst_i = 1'b0;
    #2 rst_i = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) wr(5'(1 + i), 32'(i));
    #1;
    chk("wrap16_cnt4", {28'h0, cnt_b}, 32'd0);
    chk("wrap16_cnt32", cnt_a, 32'd16);
    wr(5'd20, 32'h99);
    #1;
    chk("wrap17_cnt4", {28'h0, cnt_b}, 32'd1);

    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
